mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data-memory bus, downstream of the cpu core.
- Gives the core a console output visible in the cpu-level testbench and on hardware.
- CPU stores bytes into a small TX FIFO. An internal FSM serialises them 8N1, LSB first, on `uart_tx`.
- A status register lets firmware poll for FIFO full, FIFO empty, busy and overflow.

---
 rtl/mmio_uart_tx_pkg.sv | 29 ++
 rtl/mmio_uart_tx_if.sv | 12 +
 rtl/mmio_uart_tx_sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared UART definitions: FSM states, register offsets and STATUS bit positions.
// Used by the TX peripheral now and by the RX path later.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Word offsets on the peripheral bus
    localparam logic [1:0] TXDATA_OFF = 2'd0;
    localparam logic [1:0] STATUS_OFF = 2'd1;

    // STATUS register bit positions
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_PAR_BIT   = 4;

    // Even parity bit: makes the total number of ones (data + parity) even
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART TX peripheral.
// master = CPU side, slave = peripheral side. Read data is combinational.
interface mmio_uart_tx_if;
    logic        bus_sel;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_sel, bus_we, bus_addr, bus_wdata, input bus_rdata);
    modport slave  (input bus_sel, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Generic synchronous FIFO (circular buffer). A push into a full FIFO is still
// accepted when a pop happens in the same cycle. Head data is combinational.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_push_ok,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage array; contents need no reset, pointers/count qualify them
    always_ff @(posedge i_clk) begin
        if (o_push_ok)
            r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({o_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores bytes into a TX FIFO, an FSM
// serialises them LSB first on uart_tx (8N1 by default).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1)
// and sets STATUS bit4.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    mmio_uart_tx_if.slave       bus,
    output logic                uart_tx,
    output logic                irq_empty
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int             CW        = $clog2(FIFO_DEPTH) + 1;

    uart_state_e     r_state, w_state_n;
    logic [BW-1:0]   r_baud, w_baud_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_tx, w_tx_n;
    logic            r_ovf, r_irq;
`ifdef UART_TX_PARITY_EN
    logic            r_par, w_par_n;
`endif

    logic            w_wr_tx, w_wr_st;
    logic            w_pop, w_push_ok, w_full, w_empty, w_empty_n;
    logic            w_baud_end, w_feat;
    logic [7:0]      w_head;
    logic [CW-1:0]   w_count;
    logic            w_unused_wdata;

    assign w_wr_tx    = bus.bus_sel && bus.bus_we && (bus.bus_addr == TXDATA_OFF);
    assign w_wr_st    = bus.bus_sel && bus.bus_we && (bus.bus_addr == STATUS_OFF);
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_unused_wdata = ^bus.bus_wdata[31:8];

`ifdef UART_TX_PARITY_EN
    assign w_feat = 1'b1;
`else
    assign w_feat = 1'b0;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_push    (w_wr_tx),
        .i_pop     (w_pop),
        .i_din     (bus.bus_wdata[7:0]),
        .o_dout    (w_head),
        .o_push_ok (w_push_ok),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // FIFO empty after this edge: nothing pushed and either already empty or last entry popped
    assign w_empty_n = !w_push_ok && ((w_count == '0) || ((w_count == CW'(1)) && w_pop));

    // FSM next state; uart_tx next value is computed here and registered
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_n   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_baud_n = '0;
                w_tx_n   = 1'b1;
                if (!w_empty) begin
                    // Pop here so back-to-back frames are separated by one clock
                    w_pop     = 1'b1;
                    w_shift_n = w_head;
`ifdef UART_TX_PARITY_EN
                    w_par_n   = even_parity(w_head);
`endif
                    w_tx_n    = 1'b0;
                    w_state_n = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                    w_tx_n    = r_shift[0];
                    w_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_n = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_n    = r_par;
                        w_state_n = ST_PARITY;
`else
                        w_tx_n    = 1'b1;
                        w_state_n = ST_STOP;
`endif
                    end else begin
                        w_bit_n   = r_bit + 1'b1;
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_end) begin
                    w_baud_n  = '0;
                    w_tx_n    = 1'b1;
                    w_state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_n  = '0;
                    w_tx_n    = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_baud_n  = '0;
                w_tx_n    = 1'b1;
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // FSM, baud counter, shift register and line register; reset aborts any frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_n;
`endif
        end
    end

    // Sticky overflow (set on dropped push, cleared by STATUS write with bit3) and idle irq level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_irq <= 1'b1;
        end else begin
            if (w_wr_tx && !w_push_ok)
                r_ovf <= 1'b1;
            else if (w_wr_st && bus.bus_wdata[STAT_OVF_BIT])
                r_ovf <= 1'b0;
            r_irq <= (w_state_n == ST_IDLE) && w_empty_n;
        end
    end

    // Read mux: only STATUS returns data; TXDATA and reserved offsets read zero
    always_comb begin
        bus.bus_rdata = '0;
        if (bus.bus_sel && (bus.bus_addr == STATUS_OFF)) begin
            bus.bus_rdata[STAT_FULL_BIT]  = w_full;
            bus.bus_rdata[STAT_EMPTY_BIT] = w_empty;
            bus.bus_rdata[STAT_BUSY_BIT]  = (r_state != ST_IDLE);
            bus.bus_rdata[STAT_OVF_BIT]   = r_ovf;
            bus.bus_rdata[STAT_PAR_BIT]   = w_feat;
        end
    end

    assign uart_tx   = r_tx;
    assign irq_empty = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes frames into a queue; one frame is also checked cycle by cycle.
module tb_mmio_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          NB   = 11;
    localparam logic [31:0] FEAT = 32'h10;
`else
    localparam int          NB   = 10;
    localparam logic [31:0] FEAT = 32'h0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic uart_tx, irq_empty;
    int   cyc = 0;
    int   n_cmp = 0, n_mis = 0;
    int   stop_err = 0, par_err = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    mmio_uart_tx_if u_if ();

    mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (u_if),
        .uart_tx   (uart_tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        u_if.bus_sel = 1'b1; u_if.bus_we = 1'b1; u_if.bus_addr = a; u_if.bus_wdata = d;
        @(posedge clk); #1;
        u_if.bus_sel = 1'b0; u_if.bus_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        u_if.bus_sel = 1'b1; u_if.bus_we = 1'b0; u_if.bus_addr = a;
        #1;
        d = u_if.bus_rdata;
        u_if.bus_sel = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int lim);
        int k = 0;
        while (rx_q.size() < n && k < lim) begin tick(1); k++; end
    endtask

    // Burst of consecutive TXDATA writes; upper data bits carry junk
    task automatic burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            u_if.bus_sel = 1'b1; u_if.bus_we = 1'b1; u_if.bus_addr = 2'd0;
            u_if.bus_wdata = 32'hDEAD_0000 | 32'(first + 8'(i));
            @(posedge clk); #1;
        end
        u_if.bus_sel = 1'b0; u_if.bus_we = 1'b0;
    endtask

    // Write one byte to an idle UART and check the line level at both ends of every bit
    task automatic frame_exact(input logic [7:0] d);
        logic [31:0] s;
        logic        e;
        wr(2'd0, {24'hFFFFFF, d});
        chk("pop_cycle_tx", uart_tx, 1'b1);
        chk("pop_cycle_irq", irq_empty, 1'b0);
        tick(1);
        for (int t = 0; t < NB*C; t++) begin
            int b;
            int k;
            b = t / C; k = t % C;
            if (b == 0)          e = 1'b0;
            else if (b <= 8)     e = d[b-1];
            else if (b == NB-1)  e = 1'b1;
            else                 e = ^d;
            if (k == 0 || k == C-1) chk("frame_bit", uart_tx, e);
            if (t == 0 || t == NB*C-1) begin
                rd(2'd1, s);
                chk("frame_busy", s[2], 1'b1);
                chk("frame_irq", irq_empty, 1'b0);
            end
            tick(1);
        end
        rd(2'd1, s);
        chk("frame_end_status", s, 32'h2 | FEAT);
        chk("frame_end_irq", irq_empty, 1'b1);
        chk("frame_end_tx", uart_tx, 1'b1);
    endtask

    // Line monitor: decode frames sampled at mid-bit, record byte and start cycle
    initial begin
        logic [7:0] b;
        int         st;
        forever begin
            @(posedge clk); #1;
            if (!reset && uart_tx === 1'b0) begin
                st = cyc;
                tick(C/2);
                for (int i = 0; i < 8; i++) begin tick(C); b[i] = uart_tx; end
`ifdef UART_TX_PARITY_EN
                tick(C);
                if (uart_tx !== ^b) par_err++;
`endif
                tick(C);
                if (uart_tx !== 1'b1) stop_err++;
                rx_q.push_back(b);
                rx_t.push_back(st);
            end
        end
    end

    initial begin
        logic [31:0] s;
        int          bad;
        u_if.bus_sel = 1'b0; u_if.bus_we = 1'b0; u_if.bus_addr = 2'd0; u_if.bus_wdata = '0;
        reset = 1'b1;
        #10 reset = 1'b0;
        tick(1);

        // Reset state and quiet line
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_irq", irq_empty, 1'b1);
        rd(2'd1, s);
        chk("rst_status", s, 32'h2 | FEAT);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (uart_tx !== 1'b1 || irq_empty !== 1'b1) bad++;
            tick(1);
        end
        chk("rst_idle_bad_cycles", bad, 0);

        // Single frame 0x55, exact timing
        rx_q.delete(); rx_t.delete();
        frame_exact(8'h55);
        tick(10);
        chk("f55_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("f55_byte", rx_q[0], 8'h55);

        // Parity/odd pattern frame 0x07
        rx_q.delete(); rx_t.delete();
        frame_exact(8'h07);
        tick(10);
        chk("f07_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("f07_byte", rx_q[0], 8'h07);

        // Reserved offsets and reads of TXDATA / unselected bus
        wr(2'd2, 32'hFF);
        wr(2'd3, 32'hFF);
        rd(2'd0, s); chk("rd_txdata", s, 0);
        rd(2'd2, s); chk("rd_resv2", s, 0);
        rd(2'd3, s); chk("rd_resv3", s, 0);
        u_if.bus_addr = 2'd1; #1;
        chk("rd_unsel", u_if.bus_rdata, 0);
        rd(2'd1, s); chk("resv_status", s, 32'h2 | FEAT);
        tick(3);
        chk("resv_no_tx", uart_tx, 1'b1);

        // Five back-to-back writes: fill FIFO, no overflow, 1-clock gaps
        rx_q.delete(); rx_t.delete();
        burst(8'h41, 5);
        rd(2'd1, s); chk("b5_status", s, 32'h5 | FEAT);
        wait_rx(5, 5*(NB*C+1) + 60);
        chk("b5_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("b5_byte", rx_q[i], 8'h41 + 8'(i));
        for (int i = 0; i + 1 < rx_t.size(); i++) chk("b5_gap", rx_t[i+1] - rx_t[i], NB*C + 1);
        tick(10);
        chk("b5_irq", irq_empty, 1'b1);

        // Six writes: sixth dropped, sticky overflow, cleared only by bit3
        rx_q.delete(); rx_t.delete();
        burst(8'h61, 6);
        rd(2'd1, s); chk("ovf_status", s, 32'hD | FEAT);
        wr(2'd1, 32'h7);
        rd(2'd1, s); chk("ovf_keep", s, 32'hD | FEAT);
        wr(2'd1, 32'h8);
        rd(2'd1, s); chk("ovf_clear", s, 32'h5 | FEAT);
        wait_rx(5, 5*(NB*C+1) + 60);
        tick(100);
        chk("ovf_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_byte", rx_q[i], 8'h61 + 8'(i));
        chk("stop_errors", stop_err, 0);
        chk("parity_errors", par_err, 0);

        // Reset mid-DATA of 0xA5 with two more bytes queued
        wr(2'd0, 32'hA5);
        wr(2'd0, 32'hB1);
        wr(2'd0, 32'hB2);
        tick(8);
        chk("pre_rst_tx", uart_tx, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", uart_tx, 1'b1);
        chk("rst_mid_irq", irq_empty, 1'b1);
        rd(2'd1, s); chk("rst_mid_status", s, 32'h2 | FEAT);
        tick(2);
        reset = 1'b0;
        tick(50);
        rx_q.delete(); rx_t.delete();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (uart_tx !== 1'b1) bad++;
            tick(1);
        end
        chk("post_rst_low_cycles", bad, 0);
        chk("post_rst_frames", rx_q.size(), 0);
        rd(2'd1, s); chk("post_rst_status", s, 32'h2 | FEAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
